// File: rtl/halt_dump_unit_pkg.sv
// Shared CPU definitions: halt encoding, dump sequencer states, data-memory depth.
package halt_dump_unit_pkg;

    localparam logic [31:0] CPU_HALT_WORD     = 32'hFFFF_FFFF;
    localparam int unsigned DEFAULT_MEM_WORDS = 512;

    typedef enum logic [2:0] {
        RUN,
        SETTLE,
        READ,
        WAIT,
        PRESENT,
        DONE
    } dumpState_e;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating 32-bit cycle counter with enable and asynchronous reset.
module run_cycle_counter (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        enable,
    output logic [31:0] count
);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/halt_dump_unit.sv
// Halt detector and data-memory dump sequencer: freezes the pipeline on the
// halt word, waits a settle period, then streams memory out over valid/ready.
module halt_dump_unit
    import halt_dump_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS     = DEFAULT_MEM_WORDS,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [31:0] HALT_WORD     = CPU_HALT_WORD
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] instrW,
    output logic        cpuHalt,
    output logic        dumpRdEn,
    output logic [31:0] dumpAddr,
    input  logic [31:0] dumpData,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outAddr,
    output logic [31:0] outData,
    output logic [31:0] cycleCount,
    output logic        done
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    dumpState_e state;
    dumpState_e stateNext;

    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] settleCnt;
    logic             haltHit;
    logic             lastIndex;
    logic [31:0]      indexByteAddr;

    // Written as an if so an X/Z instruction resolves to "no halt".
    always_comb begin
        haltHit = 1'b0;
        if (instrW == HALT_WORD) begin
            haltHit = 1'b1;
        end
    end

    assign lastIndex     = (index == IDX_W'(MEM_WORDS - 1));
    assign indexByteAddr = 32'({index, 2'b00});

    run_cycle_counter uCycleCounter (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .enable ((state == RUN) && !haltHit),
        .count  (cycleCount)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (haltHit) stateNext = SETTLE;
            SETTLE:  if (settleCnt == '0) stateNext = READ;
            READ:    stateNext = WAIT;
            WAIT:    stateNext = PRESENT;
            PRESENT: begin
                if (outReady) begin
                    stateNext = lastIndex ? DONE : READ;
                end
            end
            DONE:    stateNext = DONE;
            default: stateNext = RUN;
        endcase
    end

    always_comb begin
        cpuHalt  = (state != RUN);
        dumpRdEn = 1'b0;
        dumpAddr = '0;
        outValid = 1'b0;
        done     = 1'b0;
        case (state)
            READ: begin
                dumpRdEn = 1'b1;
                dumpAddr = indexByteAddr;
            end
            PRESENT: outValid = 1'b1;
            DONE:    done     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            index     <= '0;
            settleCnt <= '0;
            outAddr   <= '0;
            outData   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (haltHit) settleCnt <= CNT_W'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (settleCnt != '0) settleCnt <= settleCnt - 1'b1;
                    else                 index     <= '0;
                end
                WAIT: begin
                    outData <= dumpData;
                    outAddr <= indexByteAddr;
                end
                PRESENT: begin
                    if (outReady && !lastIndex) index <= index + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
